pwm_capture: RTL and testbench

PWM input capture: the receive-side counterpart of the team's PWM generator. It samples an external or looped-back PWM waveform, measures its period and high time in `clk` cycles, and publishes one result per complete period. It also flags loss of signal (stuck line or 0%/100% duty). It sits behind the same AXI-lite register bank as the generator, so software can close the loop on frequency and duty.

---
 rtl/pwm_capture.sv | 125 ++++++++++++
 tb/tb_pwm_capture.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM input capture: synchronizes an asynchronous PWM line and measures its
// period and high time in clk cycles, with a sticky loss-of-signal flag.
`timescale 1ns/1ps
module pwm_capture #(
  parameter int NB          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic          i_pwm,
  input  logic          i_enable,
  input  logic [NB-1:0] i_timeout,
  output logic [NB-1:0] o_period,
  output logic [NB-1:0] o_high,
  output logic          o_valid,
  output logic          o_timeout,
  output logic          o_level
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [NB-1:0] ONES = '1;
  localparam logic [NB-1:0] ONE  = {{(NB-1){1'b0}}, 1'b1};

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s, s_d, rise, fall, tmo_hit;
  logic [NB-1:0]          cnt_per, cnt_hi, hi_lat;

  // Counters stick at all-ones so long periods read as "at least max".
  function automatic logic [NB-1:0] sat_inc(input logic [NB-1:0] v);
    return (v == ONES) ? v : v + ONE;
  endfunction

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], i_pwm};
      s_d  <= s;
    end
  end

  assign s       = sync[SYNC_STAGES-1];
  assign rise    = s & ~s_d;
  assign fall    = ~s & s_d;
  assign o_level = s;
  assign tmo_hit = (i_timeout != '0) && (cnt_per == i_timeout);

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!i_enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (rise) state_nxt = MEASURE;
        MEASURE: if (!rise && tmo_hit) state_nxt = ARM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_per   <= '0;
      cnt_hi    <= '0;
      hi_lat    <= '0;
      o_period  <= '0;
      o_high    <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (!i_enable) begin
        cnt_per   <= '0;
        cnt_hi    <= '0;
        hi_lat    <= '0;
        o_timeout <= 1'b0;
      end else begin
        case (state)
          ARM: begin
            // The first rise only opens a measurement window; nothing is published.
            if (rise) begin
              cnt_per <= ONE;
              cnt_hi  <= ONE;
            end
          end
          MEASURE: begin
            if (rise) begin
              o_period  <= cnt_per;
              o_high    <= hi_lat;
              o_valid   <= 1'b1;
              o_timeout <= 1'b0;
              cnt_per   <= ONE;
              cnt_hi    <= ONE;
            end else if (tmo_hit) begin
              o_timeout <= 1'b1;
              o_period  <= '0;
              o_high    <= '0;
            end else begin
              cnt_per <= sat_inc(cnt_per);
              // After the fall s stays low until the next rise, so cnt_hi freezes.
              if (fall)   hi_lat <= cnt_hi;
              else if (s) cnt_hi <= sat_inc(cnt_hi);
            end
          end
          default: begin
            cnt_per   <= '0;
            cnt_hi    <= '0;
            hi_lat    <= '0;
            o_timeout <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: timestamp-based reference model plus scenario tasks
// with waveform-specific expectations.
`timescale 1ns/1ps
module tb_pwm_capture;
  localparam int NB   = 8;
  localparam int SS   = 2;
  localparam int MAXV = (1 << NB) - 1;

  logic          clk = 1'b0;
  logic          i_reset, i_pwm, i_enable;
  logic [NB-1:0] i_timeout, o_period, o_high;
  logic          o_valid, o_timeout, o_level;
  int            vectors = 0, miscompares = 0;

  pwm_capture #(.NB(NB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .i_reset(i_reset), .i_pwm(i_pwm), .i_enable(i_enable),
    .i_timeout(i_timeout), .o_period(o_period), .o_high(o_high),
    .o_valid(o_valid), .o_timeout(o_timeout), .o_level(o_level)
  );

  always #5 clk = ~clk;

  // Reference model: remembers the edge index of the last rise and fall and
  // derives period/high as timestamp differences, clipped to the counter range.
  logic [NB-1:0] exp_period, exp_high;
  logic          exp_valid, exp_timeout, exp_level;
  logic          hist [0:SS];
  int            t = 0, t_rise = 0, t_fall = 0;
  bit            ready, ref_ok;
  wire           m_rise = hist[SS-1] & ~hist[SS];
  wire           m_fall = ~hist[SS-1] & hist[SS];

  function automatic logic [NB-1:0] sat(input int v);
    logic [NB-1:0] r;
    if (v >= MAXV) r = '1;
    else           r = v[NB-1:0];
    return r;
  endfunction

  always @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i <= SS; i++) hist[i] <= 1'b0;
      exp_period <= '0; exp_high <= '0; exp_valid <= 1'b0;
      exp_timeout <= 1'b0; exp_level <= 1'b0;
      ready <= 1'b0; ref_ok <= 1'b0;
    end else begin
      t <= t + 1;
      exp_valid <= 1'b0;
      for (int i = SS; i > 0; i--) hist[i] <= hist[i-1];
      hist[0]   <= i_pwm;
      exp_level <= hist[SS-2];
      if (!i_enable) begin
        ready <= 1'b0; ref_ok <= 1'b0; exp_timeout <= 1'b0;
      end else if (!ready) begin
        ready <= 1'b1;
      end else if (!ref_ok) begin
        if (m_rise) begin ref_ok <= 1'b1; t_rise <= t; end
      end else if (m_rise) begin
        exp_period <= sat(t - t_rise); exp_high <= sat(t_fall - t_rise);
        exp_valid <= 1'b1; exp_timeout <= 1'b0; t_rise <= t;
      end else if (i_timeout != '0 && sat(t - t_rise) == i_timeout) begin
        exp_timeout <= 1'b1; exp_period <= '0; exp_high <= '0; ref_ok <= 1'b0;
      end else if (m_fall) begin
        t_fall <= t;
      end
    end
  end

  wire [2*NB+2:0] got  = {o_valid, o_timeout, o_level, o_period, o_high};
  wire [2*NB+2:0] want = {exp_valid, exp_timeout, exp_level, exp_period, exp_high};

  // Waveform generator: high for wh cycles, then low, period wp.
  int cyc = 0, ph = 0, wp = 10, wh = 3, rises = 0, last_rise_cyc = 0;
  bit wave_on = 1'b0;

  task automatic tick();
    logic prev;
    @(posedge clk); #1;
    cyc++;
    prev = i_pwm;
    if (wave_on) begin
      i_pwm = (ph < wh);
      ph = (ph + 1 >= wp) ? 0 : ph + 1;
    end
    if (i_pwm && !prev) begin rises++; last_rise_cyc = cyc; end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_enable = 1'b0; i_pwm = 1'b0; i_timeout = '0; wave_on = 1'b0;
    #2;
    vectors++;
    if (got !== '0) begin miscompares++; $display("FAIL reset_async got=%h want=0", got); end
    i_pwm = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (got !== '0) begin miscompares++; $display("FAIL reset_hold got=%h want=0", got); end
    i_pwm = 1'b0;
    @(posedge clk); #1 i_reset = 1'b0;
    repeat (4) begin
      tick(); @(negedge clk); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL reset_model cyc=%0d got=%h want=%h", cyc, got, want); end
    end
  endtask

  task automatic test_steady();
    int nval = 0, first_val = -1, first_rise = -1, r0;
    i_timeout = '0; i_enable = 1'b1;
    repeat (3) begin
      tick(); @(negedge clk); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL steady_model cyc=%0d got=%h want=%h", cyc, got, want); end
    end
    wp = 10; wh = 3; ph = 0; wave_on = 1'b1; r0 = rises;
    repeat (65) begin
      tick();
      if (first_rise < 0 && rises > r0) first_rise = last_rise_cyc;
      @(negedge clk); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL steady_model cyc=%0d got=%h want=%h", cyc, got, want); end
      if (o_valid) begin
        nval++;
        if (first_val < 0) first_val = cyc;
        vectors++;
        if (o_period !== 8'd10 || o_high !== 8'd3 || cyc - last_rise_cyc != SS + 1) begin
          miscompares++;
          $display("FAIL steady_value per=%0d high=%0d lat=%0d want 10/3/%0d", o_period, o_high, cyc - last_rise_cyc, SS + 1);
        end
      end
    end
    vectors++;
    if (nval != 6 || first_val - first_rise != 10 + SS + 1) begin
      miscompares++;
      $display("FAIL steady_count valids=%0d first_delay=%0d want 6/%0d", nval, first_val - first_rise, 10 + SS + 1);
    end
  endtask

  task automatic test_duty_step();
    int k = 0;
    while (ph != 0) begin
      tick(); @(negedge clk); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL duty_model cyc=%0d got=%h want=%h", cyc, got, want); end
    end
    wh = 7;
    repeat (40) begin
      tick(); @(negedge clk); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL duty_model cyc=%0d got=%h want=%h", cyc, got, want); end
      if (o_valid) begin
        k++; vectors++;
        if (o_period !== 8'd10 || o_high !== ((k == 1) ? 8'd3 : 8'd7)) begin
          miscompares++;
          $display("FAIL duty_value n=%0d per=%0d high=%0d want 10/%0d", k, o_period, o_high, (k == 1) ? 3 : 7);
        end
      end
    end
    vectors++;
    if (k != 4) begin miscompares++; $display("FAIL duty_count valids=%0d want 4", k); end
  endtask

  task automatic test_loss();
    int rc, tmo_cyc, r0, nval;
    i_timeout = 8'd50;
    for (int lv = 0; lv < 2; lv++) begin
      while (ph != 0) begin
        tick(); @(negedge clk); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL loss_model cyc=%0d got=%h want=%h", cyc, got, want); end
      end
      tick(); @(negedge clk); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL loss_model cyc=%0d got=%h want=%h", cyc, got, want); end
      rc = last_rise_cyc;
      if (lv == 0) begin
        while (i_pwm) begin
          tick(); @(negedge clk); vectors++;
          if (got !== want) begin miscompares++; $display("FAIL loss_model cyc=%0d got=%h want=%h", cyc, got, want); end
        end
      end
      wave_on = 1'b0;
      tmo_cyc = -1;
      repeat (70) begin
        tick(); @(negedge clk); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL loss_model cyc=%0d got=%h want=%h", cyc, got, want); end
        if (o_timeout && tmo_cyc < 0) begin
          tmo_cyc = cyc; vectors++;
          if (o_period !== '0 || o_high !== '0 || cyc - rc < 49 || cyc - rc > 54) begin
            miscompares++;
            $display("FAIL loss_flag lv=%0d per=%0d high=%0d delay=%0d want 0/0/49..54", lv, o_period, o_high, cyc - rc);
          end
        end
      end
      vectors++;
      if (tmo_cyc < 0 || o_timeout !== 1'b1) begin
        miscompares++; $display("FAIL loss_timeout lv=%0d flag=%b want 1", lv, o_timeout);
      end
      ph = lv ? wh : 0; wave_on = 1'b1; r0 = rises; nval = 0;
      repeat (40) begin
        tick(); @(negedge clk); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL loss_model cyc=%0d got=%h want=%h", cyc, got, want); end
        if (o_valid) begin
          nval++;
          if (nval == 1) begin
            vectors++;
            if (o_timeout !== 1'b0 || rises - r0 != 2) begin
              miscompares++;
              $display("FAIL loss_recover lv=%0d flag=%b rises=%0d want 0/2", lv, o_timeout, rises - r0);
            end
          end
        end
      end
    end
  endtask

  task automatic test_enable_toggle();
    int r0, nval = 0;
    i_timeout = '0;
    while (ph != 5) begin
      tick(); @(negedge clk); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL enable_model cyc=%0d got=%h want=%h", cyc, got, want); end
    end
    i_enable = 1'b0;
    repeat (3) begin
      tick(); @(negedge clk); vectors++;
      if (got !== want || o_valid !== 1'b0 || o_period !== 8'd10 || o_high !== 8'd7) begin
        miscompares++; $display("FAIL enable_hold cyc=%0d got=%h want=%h", cyc, got, want);
      end
    end
    i_enable = 1'b1; r0 = rises;
    repeat (40) begin
      tick(); @(negedge clk); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL enable_model cyc=%0d got=%h want=%h", cyc, got, want); end
      if (o_valid) begin
        nval++;
        if (nval == 1) begin
          vectors++;
          if (rises - r0 != 2) begin miscompares++; $display("FAIL enable_first rises=%0d want 2", rises - r0); end
        end
      end
    end
  endtask

  task automatic test_saturation();
    int nval = 0;
    while (ph != 0) begin
      tick(); @(negedge clk); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL sat_model cyc=%0d got=%h want=%h", cyc, got, want); end
    end
    wp = 300; wh = 280;
    repeat (1000) begin
      tick(); @(negedge clk); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL sat_model cyc=%0d got=%h want=%h", cyc, got, want); end
      if (o_valid) begin
        nval++;
        if (nval >= 2) begin
          vectors++;
          if (o_period !== 8'd255 || o_high !== 8'd255) begin
            miscompares++; $display("FAIL sat_value per=%0d high=%0d want 255/255", o_period, o_high);
          end
        end
      end
    end
    vectors++;
    if (nval != 4) begin miscompares++; $display("FAIL sat_count valids=%0d want 4", nval); end
  endtask

  task automatic test_async_reset();
    int r0, nval = 0;
    wp = 10; wh = 3; ph = 0;
    repeat (25) begin
      tick(); @(negedge clk); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL areset_model cyc=%0d got=%h want=%h", cyc, got, want); end
    end
    while (ph != 5) begin
      tick(); @(negedge clk); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL areset_model cyc=%0d got=%h want=%h", cyc, got, want); end
    end
    #2 i_reset = 1'b1;
    #1 vectors++;
    if (got !== '0) begin miscompares++; $display("FAIL areset_clear got=%h want=0", got); end
    @(posedge clk); @(posedge clk); #3 i_reset = 1'b0;
    r0 = rises;
    repeat (40) begin
      tick(); @(negedge clk); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL areset_model cyc=%0d got=%h want=%h", cyc, got, want); end
      if (o_valid) begin
        nval++; vectors++;
        if ((nval == 1 && rises - r0 != 2) || o_period !== 8'd10 || o_high !== 8'd3) begin
          miscompares++;
          $display("FAIL areset_restart n=%0d rises=%0d per=%0d high=%0d want 2/10/3", nval, rises - r0, o_period, o_high);
        end
      end
    end
  endtask

  task automatic test_random();
    bit drop;
    repeat (12) begin
      wp = int'($urandom_range(40, 2));
      wh = int'($urandom_range(wp - 1, 1));
      ph = 0;
      i_timeout = ($urandom_range(2, 0) == 0) ? NB'($urandom_range(60, 1)) : '0;
      drop = ($urandom_range(3, 0) == 0);
      repeat (120) begin
        tick();
        if (drop) i_enable = ($urandom_range(19, 0) != 0);
        @(negedge clk); vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL random_model cyc=%0d P=%0d H=%0d got=%h want=%h", cyc, wp, wh, got, want);
        end
      end
      i_enable = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_duty_step();
    test_loss();
    test_enable_toggle();
    test_saturation();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
